// File: rtl/pattern_pkg.sv
`default_nettype none
// ============================================================================
// pattern_pkg : shared pattern constants, FSM state type and wrap rule
// Rev 1.0
// ============================================================================
package pattern_pkg;

    localparam logic [31:0] PATTERN_SEED = 32'h0001_0203;
    localparam logic [31:0] PATTERN_STEP = 32'h0404_0404;
    localparam logic [31:0] PATTERN_LAST = 32'hFCFD_FEFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    // Byte lanes never carry into each other; the last word wraps to the seed.
    function automatic logic [31:0] pattern_next(input logic [31:0] cur);
        return (cur == PATTERN_LAST) ? PATTERN_SEED : cur + PATTERN_STEP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_gen.sv
`default_nettype none
// ============================================================================
// pattern_gen : registered expected-word generator (load to seed, advance)
// Rev 1.0
// ============================================================================
module pattern_gen
    import pattern_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        advance,
    output logic [31:0] value
);

    logic [31:0] value_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= PATTERN_SEED;
        end else if (load) begin
            value_q <= PATTERN_SEED;
        end else if (advance) begin
            value_q <= pattern_next(value_q);
        end
    end

    assign value = value_q;

endmodule
`default_nettype wire

// File: rtl/pattern_checker.sv
`default_nettype none
// ============================================================================
// pattern_checker : Avalon-MM burst read master verifying the SDRAM pattern
// Optional first-mismatch capture: define PATTERN_CHECKER_FIRST_ERR_EN
// Rev 1.0
// ============================================================================
module pattern_checker
    import pattern_pkg::*;
#(
    parameter int                 ADDRESS_WIDTH     = 32,
    parameter int                 DATA_WIDTH        = 32,
    parameter int                 BYTE_ENABLE_WIDTH = 4,
    parameter int                 BURST_WIDTH       = 4,
    parameter int                 BURST_COUNT       = 8,
    parameter int                 NUM_BURSTS        = 65536,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS = 32'h3800_0000,
    parameter int                 ERR_WIDTH         = 16
)(
    input  logic                         clk,
    input  logic                         reset,
    output logic [ADDRESS_WIDTH-1:0]     master_address,
    output logic                         master_read,
    output logic [BURST_WIDTH-1:0]       master_burstcount,
    output logic [BYTE_ENABLE_WIDTH-1:0] master_byteenable,
    input  logic                         master_waitrequest,
    input  logic [DATA_WIDTH-1:0]        master_readdata,
    input  logic                         master_readdatavalid,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [ERR_WIDTH-1:0]         error_count,
    output logic [ADDRESS_WIDTH-1:0]     first_err_addr,
    output logic [DATA_WIDTH-1:0]        first_err_data
);

    localparam int BURST_CNT_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam logic [BURST_CNT_W-1:0]   LAST_BURST  = BURST_CNT_W'(NUM_BURSTS - 1);
    localparam logic [BURST_WIDTH-1:0]   LAST_BEAT   = BURST_WIDTH'(BURST_COUNT - 1);
    localparam logic [ADDRESS_WIDTH-1:0] BURST_BYTES = ADDRESS_WIDTH'(BURST_COUNT * 4);
    localparam logic [ERR_WIDTH-1:0]     ERR_MAX     = '1;

    state_t                   state_q, state_d;
    logic                     read_q, read_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [BURST_WIDTH-1:0]   beat_q, beat_d;
    logic [BURST_CNT_W-1:0]   burst_q, burst_d;
    logic [ERR_WIDTH-1:0]     err_q, err_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     pass_q, pass_d;

    logic        beat_valid;
    logic        mismatch;
    logic        load;
    logic [31:0] expected;

    pattern_gen u_pattern_gen (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .advance (beat_valid),
        .value   (expected)
    );

    // Beats outside DATA belong to no request of this pass and are dropped.
    assign beat_valid = (state_q == DATA) && master_readdatavalid;
    assign mismatch   = beat_valid && (master_readdata != expected);
    assign load       = start && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d = state_q;
        read_d  = read_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        burst_d = burst_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = REQ;
                    read_d  = 1'b1;
                    addr_d  = BASE_ADDRESS;
                    beat_d  = '0;
                    burst_d = '0;
                    err_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            REQ: begin
                if (read_q && !master_waitrequest) begin
                    read_d  = 1'b0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (beat_valid) begin
                    if (mismatch && (err_q != ERR_MAX)) begin
                        err_d = err_q + ERR_WIDTH'(1);
                    end
                    beat_d = beat_q + BURST_WIDTH'(1);
                    if (beat_q == LAST_BEAT) begin
                        if (burst_q == LAST_BURST) begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            pass_d  = (err_d == '0);
                        end else begin
                            state_d = REQ;
                            read_d  = 1'b1;
                            addr_d  = addr_q + BURST_BYTES;
                            burst_d = burst_q + BURST_CNT_W'(1);
                            beat_d  = '0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            read_q  <= 1'b0;
            addr_q  <= BASE_ADDRESS;
            beat_q  <= '0;
            burst_q <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            burst_q <= burst_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

`ifdef PATTERN_CHECKER_FIRST_ERR_EN
    logic [ADDRESS_WIDTH-1:0] fe_addr_q;
    logic [DATA_WIDTH-1:0]    fe_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fe_addr_q <= '0;
            fe_data_q <= '0;
        end else if (load) begin
            fe_addr_q <= '0;
            fe_data_q <= '0;
        end else if (mismatch && (err_q == '0)) begin
            fe_addr_q <= addr_q + (ADDRESS_WIDTH'(beat_q) << 2);
            fe_data_q <= master_readdata;
        end
    end

    assign first_err_addr = fe_addr_q;
    assign first_err_data = fe_data_q;
`else
    assign first_err_addr = '0;
    assign first_err_data = '0;
`endif

    assign master_address    = addr_q;
    assign master_read       = read_q;
    assign master_burstcount = BURST_WIDTH'(BURST_COUNT);
    assign master_byteenable = '1;
    assign busy              = busy_q;
    assign done              = done_q;
    assign pass              = pass_q;
    assign error_count       = err_q;

endmodule
`default_nettype wire
